fixed_dot_accum: RTL

- Streaming fixed-point dot-product accumulator for the MX attention datapath.
- Each beat carries LANES signed element pairs. The block multiplies each pair, sums the lanes, and accumulates across beats until a beat marked last.
- It emits one full-precision sum with frac width 2*IN_FRAC_WIDTH. This result feeds the fixed_round requantisation stage directly downstream, which narrows it to the operator's output format.

---
 rtl/fixed_dot_accum.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/fixed_dot_accum.sv
// Streaming fixed-point dot-product accumulator: per-beat lane products are summed,
// registered, then accumulated at full precision until the last beat of a vector.
module fixed_dot_accum #(
  parameter int IN_WIDTH      = 8,
  parameter int IN_FRAC_WIDTH = 4,
  parameter int LANES         = 4,
  parameter int MAX_BEATS     = 64,
  localparam int ACC_WIDTH    = 2*IN_WIDTH + $clog2(LANES) + $clog2(MAX_BEATS)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [LANES*IN_WIDTH-1:0]     data_in_a,
  input  logic [LANES*IN_WIDTH-1:0]     data_in_b,
  input  logic                          data_in_last,
  input  logic                          data_in_valid,
  output logic                          data_in_ready,
  output logic signed [ACC_WIDTH-1:0]   data_out,
  output logic                          data_out_overflow,
  output logic                          data_out_valid,
  input  logic                          data_out_ready
);

  localparam int CNT_W = $clog2(MAX_BEATS) + 1;
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(MAX_BEATS + 1);
  localparam logic [CNT_W-1:0] CNT_OVER = CNT_W'(MAX_BEATS);
  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  if (((LANES & (LANES-1)) != 0) || ((MAX_BEATS & (MAX_BEATS-1)) != 0) ||
      (MAX_BEATS < 2) || (IN_FRAC_WIDTH > IN_WIDTH)) begin : g_bad_param
    $error("fixed_dot_accum: illegal parameter combination");
  end

  typedef enum logic [1:0] {ACCUM = 2'd0, DRAIN = 2'd1, HOLD = 2'd2} state_t;

  state_t                        state_q, state_d;
  logic                          run_q;
  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic signed [ACC_WIDTH-1:0]   lane_sum;
  logic signed [ACC_WIDTH-1:0]   sum_p1_q;
  logic                          vld_p1_q, last_p1_q, over_p1_q;
  logic signed [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic signed [ACC_WIDTH:0]     acc_wide;
  logic                          ovf_q, ovf_d;
  logic                          in_fire, out_fire, beat_over;

  function automatic logic signed [2*IN_WIDTH-1:0] mul_lane(
    input logic signed [IN_WIDTH-1:0] a,
    input logic signed [IN_WIDTH-1:0] b
  );
    logic signed [2*IN_WIDTH-1:0] ax, bx;
    ax = a;
    bx = b;
    return ax * bx;
  endfunction

  // Once a vector has overrun, the result is pinned to the limit in the sum's direction.
  function automatic logic signed [ACC_WIDTH-1:0] sat_acc(
    input logic signed [ACC_WIDTH:0] x,
    input logic                      force_sat
  );
    if (!force_sat)       return x[ACC_WIDTH-1:0];
    else if (x[ACC_WIDTH]) return ACC_MIN;
    else                   return ACC_MAX;
  endfunction

  assign data_in_ready     = run_q && (state_q == ACCUM);
  assign data_out_valid    = (state_q == HOLD);
  assign data_out          = acc_q;
  assign data_out_overflow = ovf_q;
  assign in_fire           = data_in_valid && data_in_ready;
  assign out_fire          = data_out_valid && data_out_ready;
  assign beat_over         = (cnt_q >= CNT_OVER);

  always_comb begin
    lane_sum = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_sum = lane_sum + ACC_WIDTH'(mul_lane(data_in_a[i*IN_WIDTH +: IN_WIDTH],
                                                data_in_b[i*IN_WIDTH +: IN_WIDTH]));
    end
  end

  // Stage 1: registered lane sum with its valid, last and overrun flags
  always_ff @(posedge clk) begin
    if (in_fire) sum_p1_q <= lane_sum;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1_q  <= 1'b0;
      last_p1_q <= 1'b0;
      over_p1_q <= 1'b0;
    end else begin
      vld_p1_q  <= in_fire;
      last_p1_q <= in_fire && data_in_last;
      over_p1_q <= in_fire && beat_over;
    end
  end

  // Stage 2: accumulator, beat counter and control FSM
  assign acc_wide = {acc_q[ACC_WIDTH-1], acc_q} + {sum_p1_q[ACC_WIDTH-1], sum_p1_q};

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    if (in_fire && (cnt_q != CNT_SAT)) cnt_d = cnt_q + 1'b1;
    if (vld_p1_q) begin
      ovf_d = ovf_q || over_p1_q;
      acc_d = sat_acc(acc_wide, ovf_d);
    end
    case (state_q)
      ACCUM: if (in_fire && data_in_last) state_d = DRAIN;
      DRAIN: if (vld_p1_q && last_p1_q)   state_d = HOLD;
      HOLD: begin
        if (out_fire) begin
          state_d = ACCUM;
          acc_d   = '0;
          ovf_d   = 1'b0;
          cnt_d   = '0;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACCUM;
      run_q   <= 1'b0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      run_q   <= 1'b1;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
